// File: rtl/imm_pipe_unit.sv
// imm_pipe_unit: registered RISC-V immediate generator with 2-entry skid buffer (in_* valid/ready entry in, out_* imm/tag/illegal entry out, flush drops all entries)
module imm_pipe_unit #(
  parameter int XLEN = 32,
  parameter int TAGW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     in_instr,
  input  logic [2:0]      in_type,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [TAGW-1:0] out_tag,
  output logic            out_illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_n;
  logic [31:7] ins;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [XLEN-1:0] imm, shamt, skid_imm;
  logic [TAGW-1:0] skid_tag;
  logic ill, skid_ill, in_fire, out_fire, ld_main_in, ld_skid, ld_main_skid;
  assign ins = in_instr;
  assign i_imm = {{20{ins[31]}}, ins[31:20]};
  assign s_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign b_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign u_imm = {ins[31:12], 12'b0};
  assign j_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign shamt = XLEN == 64 ? XLEN'(ins[25:20]) : (ins[25] ? '0 : XLEN'(ins[24:20]));
  assign ill = (in_type == 3'd7) & (XLEN == 32) & ins[25];
  always_comb begin
    imm = in_type == 3'd1 ? XLEN'($signed(i_imm)) :
          in_type == 3'd2 ? XLEN'($signed(s_imm)) :
          in_type == 3'd3 ? XLEN'($signed(b_imm)) :
          in_type == 3'd4 ? XLEN'($signed(u_imm)) :
          in_type == 3'd5 ? XLEN'($signed(j_imm)) :
          in_type == 3'd6 ? XLEN'(ins[19:15]) :
          in_type == 3'd7 ? shamt : '0;
  end
  assign in_ready = (state != FULL) & ~rst;
  assign out_valid = state != EMPTY;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_comb begin
    state_n = state;
    ld_main_in = 1'b0;
    ld_skid = 1'b0;
    ld_main_skid = 1'b0;
    if (flush) state_n = EMPTY;
    else if (state == EMPTY) begin
      state_n = in_fire ? ONE : EMPTY;
      ld_main_in = in_fire;
    end else if (state == ONE) begin
      state_n = (in_fire & ~out_fire) ? FULL : (~in_fire & out_fire) ? EMPTY : ONE;
      ld_main_in = in_fire & out_fire;
      ld_skid = in_fire & ~out_fire;
    end else begin
      state_n = out_fire ? ONE : FULL;
      ld_main_skid = out_fire;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      out_imm <= '0;
      out_tag <= '0;
      out_illegal <= 1'b0;
    end else begin
      state <= state_n;
      if (ld_main_in) begin
        out_imm <= imm;
        out_tag <= in_tag;
        out_illegal <= ill;
      end else if (ld_main_skid) begin
        out_imm <= skid_imm;
        out_tag <= skid_tag;
        out_illegal <= skid_ill;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (ld_skid) begin
      skid_imm <= imm;
      skid_tag <= in_tag;
      skid_ill <= ill;
    end
  end
endmodule

// File: tb/tb_imm_pipe_unit.sv
// tb_imm_pipe_unit: scoreboard bench driving XLEN=32 and XLEN=64 instances with the same directed vectors
module tb_imm_pipe_unit;
  localparam int NV = 14;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [24:0] in_instr;
  logic [2:0] in_type;
  logic [31:0] in_tag;
  logic rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic i32;
    logic i64;
    logic [31:0] tag;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0, errors = 0, cur = 0;
  logic [31:0] v_ins [NV] = '{32'hFFF00093, 32'hFE202C23, 32'hFE000EE3, 32'h800000B7, 32'h000FD073,
                              32'h02009093, 32'h0080006F, 32'hFFDFF0EF, 32'hFFFFFFFF, 32'h01F09093,
                              32'h7FF00093, 32'h12345037, 32'h02009093, 32'h00008073};
  logic [2:0] v_typ [NV] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7, 3'd5, 3'd5, 3'd0, 3'd7, 3'd1, 3'd4, 3'd1, 3'd6};
  logic [31:0] v_e32 [NV] = '{32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h80000000, 32'h1F,
                              32'h0, 32'h8, 32'hFFFFFFFC, 32'h0, 32'h1F, 32'h7FF, 32'h12345000, 32'h20, 32'h1};
  logic [63:0] v_e64 [NV] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
                              64'hFFFFFFFF80000000, 64'h1F, 64'h20, 64'h8, 64'hFFFFFFFFFFFFFFFC, 64'h0,
                              64'h1F, 64'h7FF, 64'h12345000, 64'h20, 64'h1};
  logic v_ill [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  assign in_instr = v_ins[cur][31:7];
  assign in_type = v_typ[cur];
  always #5 clk = ~clk;
  imm_pipe_unit #(.XLEN(32), .TAGW(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32)
  );
  imm_pipe_unit #(.XLEN(64), .TAGW(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int v, input logic [31:0] tag);
    int n = 0;
    cur = v;
    in_tag = tag;
    in_valid = 1'b1;
    while (!rdy32 && n < 100) begin
      cyc();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: tag %h not accepted in 100 cycles, expected acceptance", tag);
    end else cyc();
  endtask
  always @(negedge clk) begin
    if (ov32 & out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: tag %h emitted, expected no entry", tag32);
      end else begin
        me = q.pop_front();
        chk("imm32", 64'(imm32), 64'(me.e32));
        chk("tag32", 64'(tag32), 64'(me.tag));
        chk("ill32", 64'(ill32), 64'(me.i32));
        chk("ov64", 64'(ov64), 64'd1);
        chk("imm64", imm64, me.e64);
        chk("tag64", 64'(tag64), 64'(me.tag));
        chk("ill64", 64'(ill64), 64'(me.i64));
      end
    end
    if (rst | flush) q.delete();
    else if (in_valid & rdy32) q.push_back('{v_e32[cur], v_e64[cur], v_ill[cur], 1'b0, in_tag});
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    int sent = 0, n = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_tag = '0;
    repeat (3) cyc();
    chk("rst_ov32", 64'(ov32), 0);
    chk("rst_imm32", 64'(imm32), 0);
    chk("rst_tag32", 64'(tag32), 0);
    chk("rst_ill32", 64'(ill32), 0);
    chk("rst_rdy32", 64'(rdy32), 0);
    chk("rst_imm64", imm64, 0);
    chk("rst_ov64", 64'(ov64), 0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 64'(rdy32), 1);
    out_ready = 1'b1;
    chk("ov_before_first", 64'(ov32), 0);
    for (int i = 0; i < NV; i++) begin
      send(i, 32'h100 + i);
      if (i == 0) chk("latency_ov32", 64'(ov32), 1);
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("stream_drained", 64'(q.size()), 0);
    out_ready = 1'b0;
    send(0, 32'd1);
    send(1, 32'd2);
    cur = 2;
    in_tag = 32'd3;
    in_valid = 1'b1;
    chk("bp_rdy", 64'(rdy32), 0);
    repeat (3) begin
      cyc();
      chk("bp_hold_rdy", 64'(rdy32), 0);
      chk("bp_hold_ov", 64'(ov32), 1);
      chk("bp_hold_tag", 64'(tag32), 1);
      chk("bp_hold_imm", 64'(imm32), 64'(v_e32[0]));
    end
    out_ready = 1'b1;
    send(2, 32'd3);
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("bp_rdy_again", 64'(rdy32), 1);
    chk("bp_drained", 64'(q.size()), 0);
    out_ready = 1'b0;
    send(3, 32'd10);
    cur = 4;
    in_tag = 32'd11;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush1_ov", 64'(ov32), 0);
    chk("flush1_rdy", 64'(rdy32), 1);
    cyc();
    chk("flush1_dropped", 64'(ov32), 0);
    send(3, 32'd20);
    send(4, 32'd21);
    cur = 5;
    in_tag = 32'd22;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush2_ov", 64'(ov32), 0);
    chk("flush2_rdy", 64'(rdy32), 1);
    out_ready = 1'b1;
    send(6, 32'd30);
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("flush_drained", 64'(q.size()), 0);
    out_ready = 1'b0;
    send(5, 32'd40);
    send(1, 32'd41);
    in_valid = 1'b0;
    chk("pre_rst_ill", 64'(ill32), 1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_ov", 64'(ov32), 0);
    chk("mid_rst_imm64", imm64, 0);
    chk("mid_rst_tag", 64'(tag32), 0);
    chk("mid_rst_ill", 64'(ill32), 0);
    chk("mid_rst_rdy", 64'(rdy32), 0);
    cyc();
    chk("mid_rst_rdy2", 64'(rdy32), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", 64'(rdy32), 1);
    cyc();
    while (sent < 60 && n < 3000) begin
      in_valid = $urandom_range(0, 2) != 0;
      cur = $urandom_range(0, NV - 1);
      in_tag = $urandom;
      out_ready = $urandom_range(0, 1) == 1;
      #1;
      if (in_valid && rdy32) sent++;
      cyc();
      n++;
    end
    chk("rand_sent", 64'(sent), 60);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      cyc();
      n++;
    end
    cyc();
    chk("rand_drained", 64'(q.size()), 0);
    chk("final_ov", 64'(ov32), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
